// File: rtl/logic_axi4_stream_packet_arbiter.sv
// Packet-aware round-robin arbiter sharing one registered AXI4-Stream output among INPUTS requesters.
// Define LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN to hold the grant until tlast; otherwise the grant is released every beat.
`ifndef LOGIC_AXI4_STREAM_TDATA_BYTES
`define LOGIC_AXI4_STREAM_TDATA_BYTES 4
`endif
`ifndef LOGIC_AXI4_STREAM_TDEST_WIDTH
`define LOGIC_AXI4_STREAM_TDEST_WIDTH 4
`endif
`ifndef LOGIC_AXI4_STREAM_TUSER_WIDTH
`define LOGIC_AXI4_STREAM_TUSER_WIDTH 1
`endif
`ifndef LOGIC_AXI4_STREAM_TID_WIDTH
`define LOGIC_AXI4_STREAM_TID_WIDTH 4
`endif

module logic_axi4_stream_packet_arbiter #(
  parameter int unsigned INPUTS      = 4,
  parameter int unsigned TDATA_BYTES = `LOGIC_AXI4_STREAM_TDATA_BYTES,
  parameter int unsigned TDEST_WIDTH = `LOGIC_AXI4_STREAM_TDEST_WIDTH,
  parameter int unsigned TUSER_WIDTH = `LOGIC_AXI4_STREAM_TUSER_WIDTH,
  parameter int unsigned TID_WIDTH   = `LOGIC_AXI4_STREAM_TID_WIDTH
) (
  input  logic                                    aclk,
  input  logic                                    areset_n,
  input  logic [INPUTS-1:0]                       rx_tvalid,
  output logic [INPUTS-1:0]                       rx_tready,
  input  logic [INPUTS-1:0]                       rx_tlast,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0][7:0] rx_tdata,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0]      rx_tstrb,
  input  logic [INPUTS-1:0][TDATA_BYTES-1:0]      rx_tkeep,
  input  logic [INPUTS-1:0][TDEST_WIDTH-1:0]      rx_tdest,
  input  logic [INPUTS-1:0][TUSER_WIDTH-1:0]      rx_tuser,
  input  logic [INPUTS-1:0][TID_WIDTH-1:0]        rx_tid,
  output logic                                    tx_tvalid,
  output logic                                    tx_tlast,
  output logic [TDATA_BYTES-1:0][7:0]             tx_tdata,
  output logic [TDATA_BYTES-1:0]                  tx_tstrb,
  output logic [TDATA_BYTES-1:0]                  tx_tkeep,
  output logic [TDEST_WIDTH-1:0]                  tx_tdest,
  output logic [TUSER_WIDTH-1:0]                  tx_tuser,
  output logic [TID_WIDTH-1:0]                    tx_tid,
  input  logic                                    tx_tready,
  output logic [$clog2(INPUTS)-1:0]               grant,
  output logic                                    busy
);

  localparam int unsigned GW = $clog2(INPUTS);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           pick;
  logic                    lane_ready;
  logic                    load;
  logic                    release_grant;

  logic                    tx_tvalid_q, tx_tvalid_d;
  logic                    tx_tlast_q, tx_tlast_d;
  logic [TDATA_BYTES-1:0][7:0] tx_tdata_q, tx_tdata_d;
  logic [TDATA_BYTES-1:0]  tx_tstrb_q, tx_tstrb_d;
  logic [TDATA_BYTES-1:0]  tx_tkeep_q, tx_tkeep_d;
  logic [TDEST_WIDTH-1:0]  tx_tdest_q, tx_tdest_d;
  logic [TUSER_WIDTH-1:0]  tx_tuser_q, tx_tuser_d;
  logic [TID_WIDTH-1:0]    tx_tid_q, tx_tid_d;

  // First valid requester at or after ptr_q, wrapping modulo INPUTS.
  always_comb begin
    logic [GW:0] idx;
    logic        found;
    pick  = ptr_q;
    found = 1'b0;
    for (int unsigned off = 0; off < INPUTS; off++) begin
      idx = {1'b0, ptr_q} + (GW+1)'(off);
      if (idx >= (GW+1)'(INPUTS)) idx = idx - (GW+1)'(INPUTS);
      if (!found && rx_tvalid[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

  assign lane_ready = (state_q == LOCKED) && (!tx_tvalid_q || tx_tready);
  assign load       = lane_ready && rx_tvalid[grant_q];

`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN
  assign release_grant = rx_tlast[grant_q];
`else
  assign release_grant = 1'b1;
`endif

  always_comb begin
    rx_tready          = '0;
    rx_tready[grant_q] = lane_ready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|rx_tvalid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (load && release_grant) begin
          state_d = IDLE;
          ptr_d   = (grant_q == GW'(INPUTS-1)) ? '0 : grant_q + 1'b1;
        end
      end
    endcase
  end

  // The output stage drains independently of the arbitration state.
  always_comb begin
    tx_tvalid_d = tx_tvalid_q;
    tx_tlast_d  = tx_tlast_q;
    tx_tdata_d  = tx_tdata_q;
    tx_tstrb_d  = tx_tstrb_q;
    tx_tkeep_d  = tx_tkeep_q;
    tx_tdest_d  = tx_tdest_q;
    tx_tuser_d  = tx_tuser_q;
    tx_tid_d    = tx_tid_q;
    if (load) begin
      tx_tvalid_d = 1'b1;
      tx_tlast_d  = rx_tlast[grant_q];
      tx_tdata_d  = rx_tdata[grant_q];
      tx_tstrb_d  = rx_tstrb[grant_q];
      tx_tkeep_d  = rx_tkeep[grant_q];
      tx_tdest_d  = rx_tdest[grant_q];
      tx_tuser_d  = rx_tuser[grant_q];
      tx_tid_d    = rx_tid[grant_q];
    end else if (tx_tready) begin
      tx_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      tx_tvalid_q <= 1'b0;
      tx_tlast_q  <= 1'b0;
      tx_tdata_q  <= '0;
      tx_tstrb_q  <= '0;
      tx_tkeep_q  <= '0;
      tx_tdest_q  <= '0;
      tx_tuser_q  <= '0;
      tx_tid_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      tx_tvalid_q <= tx_tvalid_d;
      tx_tlast_q  <= tx_tlast_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tstrb_q  <= tx_tstrb_d;
      tx_tkeep_q  <= tx_tkeep_d;
      tx_tdest_q  <= tx_tdest_d;
      tx_tuser_q  <= tx_tuser_d;
      tx_tid_q    <= tx_tid_d;
    end
  end

  assign tx_tvalid = tx_tvalid_q;
  assign tx_tlast  = tx_tlast_q;
  assign tx_tdata  = tx_tdata_q;
  assign tx_tstrb  = tx_tstrb_q;
  assign tx_tkeep  = tx_tkeep_q;
  assign tx_tdest  = tx_tdest_q;
  assign tx_tuser  = tx_tuser_q;
  assign tx_tid    = tx_tid_q;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_logic_axi4_stream_packet_arbiter.sv
// Self-checking bench for logic_axi4_stream_packet_arbiter: vector table, directed sequences, randomized traffic vs. reference model.
`timescale 1ns/1ps
module tb_logic_axi4_stream_packet_arbiter;

  localparam int unsigned NIN = 4;
  localparam int unsigned NB  = 2;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  strb;
    logic [1:0]  keep;
    logic [3:0]  dest;
    logic [3:0]  user;
    logic [3:0]  tid;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic [1:0]  e_grant;
    logic        e_txv;
    logic [15:0] e_data;
  } vec_t;

  logic                         aclk = 1'b0;
  logic                         areset_n;
  logic [NIN-1:0]               rx_tvalid, rx_tready, rx_tlast;
  logic [NIN-1:0][NB-1:0][7:0]  rx_tdata;
  logic [NIN-1:0][NB-1:0]       rx_tstrb, rx_tkeep;
  logic [NIN-1:0][3:0]          rx_tdest, rx_tuser, rx_tid;
  logic                         tx_tvalid, tx_tlast, tx_tready;
  logic [NB-1:0][7:0]           tx_tdata;
  logic [NB-1:0]                tx_tstrb, tx_tkeep;
  logic [3:0]                   tx_tdest, tx_tuser, tx_tid;
  logic [1:0]                   grant;
  logic                         busy;

  logic_axi4_stream_packet_arbiter #(
    .INPUTS(NIN), .TDATA_BYTES(NB), .TDEST_WIDTH(4), .TUSER_WIDTH(4), .TID_WIDTH(4)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .rx_tdata(rx_tdata), .rx_tstrb(rx_tstrb), .rx_tkeep(rx_tkeep),
    .rx_tdest(rx_tdest), .rx_tuser(rx_tuser), .rx_tid(rx_tid),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tdata(tx_tdata),
    .tx_tstrb(tx_tstrb), .tx_tkeep(tx_tkeep), .tx_tdest(tx_tdest),
    .tx_tuser(tx_tuser), .tx_tid(tx_tid), .tx_tready(tx_tready),
    .grant(grant), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: source queues, arbitration bookkeeping, output register content.
  beat_t          lq[NIN][$];
  beat_t          tx_log[$];
  logic [NIN-1:0] en, held;
  logic           txr;
  bit             m_locked, m_txv;
  int unsigned    m_grant, m_ptr;
  beat_t          m_tx;
  int unsigned    n_pushed, n_tx;

  function automatic bit releases(input logic last);
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN
    return last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic beat_t mk(input int unsigned lane, input int unsigned n, input logic last);
    beat_t b;
    b.data = {4'(lane), 4'h0, 8'(n)};
    b.strb = 2'(n + 1);
    b.keep = 2'b11;
    b.dest = 4'(lane);
    b.user = 4'(n);
    b.tid  = 4'(lane + n);
    b.last = last;
    return b;
  endfunction

  function automatic logic [15:0] exp_fair(input int unsigned k);
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN
    return {4'((k / 2) % 4), 4'h0, 8'((k / 8) * 2 + k % 2)};
`else
    return {4'(k % 4), 4'h0, 8'(k / 4)};
`endif
  endfunction

  task automatic model_reset();
    m_locked = 0; m_txv = 0; m_grant = 0; m_ptr = 0;
    m_tx = '{default: '0};
  endtask

  task automatic drive();
    for (int i = 0; i < NIN; i++) begin
      rx_tvalid[i] = en[i] && (lq[i].size() > 0);
      if (lq[i].size() > 0) begin
        rx_tdata[i] = lq[i][0].data; rx_tstrb[i] = lq[i][0].strb; rx_tkeep[i] = lq[i][0].keep;
        rx_tdest[i] = lq[i][0].dest; rx_tuser[i] = lq[i][0].user; rx_tid[i]  = lq[i][0].tid;
        rx_tlast[i] = lq[i][0].last;
      end else begin
        rx_tdata[i] = '0; rx_tstrb[i] = '0; rx_tkeep[i] = '0;
        rx_tdest[i] = '0; rx_tuser[i] = '0; rx_tid[i] = '0; rx_tlast[i] = 1'b0;
      end
    end
    tx_tready = txr;
  endtask

  // One clock: drive at negedge, check against the model, advance the model across the posedge.
  task automatic step();
    logic [NIN-1:0] exp_rdy;
    bit             acc, found;
    int unsigned    g;
    beat_t          b, o;
    drive();
    #1;
    exp_rdy = '0;
    if (m_locked && (!m_txv || txr)) exp_rdy[m_grant] = 1'b1;
    chk("rx_tready", rx_tready, exp_rdy);
    chk("busy", busy, m_locked);
    chk("grant", grant, m_grant);
    chk("tx_tvalid", tx_tvalid, m_txv);
    if (m_txv) begin
      chk("tx_tdata", tx_tdata, m_tx.data);
      chk("tx_tlast", tx_tlast, m_tx.last);
      chk("tx_side", {tx_tstrb, tx_tkeep, tx_tdest, tx_tuser, tx_tid},
          {m_tx.strb, m_tx.keep, m_tx.dest, m_tx.user, m_tx.tid});
    end
    if (tx_tvalid && tx_tready) begin
      o.data = tx_tdata; o.strb = tx_tstrb; o.keep = tx_tkeep; o.dest = tx_tdest;
      o.user = tx_tuser; o.tid = tx_tid; o.last = tx_tlast;
      tx_log.push_back(o);
      n_tx++;
    end
    acc = m_locked && exp_rdy[m_grant] && rx_tvalid[m_grant];
    g   = m_grant;
    b   = m_tx;
    held = rx_tvalid;
    if (acc) begin
      b = lq[g].pop_front();
      m_tx = b; m_txv = 1;
      held[g] = 1'b0;
    end else if (txr) begin
      m_txv = 0;
    end
    if (!m_locked) begin
      if (rx_tvalid != '0) begin
        found = 0;
        for (int unsigned off = 0; off < NIN; off++) begin
          if (!found && rx_tvalid[(m_ptr + off) % NIN]) begin
            m_grant = (m_ptr + off) % NIN;
            found = 1;
          end
        end
        m_locked = 1;
      end
    end else if (acc && releases(b.last)) begin
      m_locked = 0;
      m_ptr = (g + 1) % NIN;
    end
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    for (int i = 0; i < NIN; i++) lq[i].delete();
    en = '0; held = '0; txr = 1'b0;
    drive();
    model_reset();
    tx_log.delete();
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
  endtask

  vec_t tbl[14];
  logic [15:0] e_lane_data[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-beat packets only, so these vectors hold with and without packet lock.
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 16'h0000};
    tbl[3]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 16'hB002};
    tbl[4]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 16'h0000};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 16'hB003};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 16'hB003};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 16'hB003};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 16'hB000};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 16'hB000};
    tbl[10] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 16'hB001};
    tbl[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h0000};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 16'hB000};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};

    areset_n = 1'b0;
    en = '0; held = '0; txr = 1'b1;
    model_reset();
    for (int i = 0; i < NIN; i++) begin
      rx_tdata[i] = 16'hB000 | 16'(i); rx_tlast[i] = 1'b1;
      rx_tstrb[i] = '1; rx_tkeep[i] = '1; rx_tdest[i] = '0; rx_tuser[i] = '0; rx_tid[i] = '0;
    end
    rx_tvalid = '1;
    tx_tready = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    chk("reset_rx_tready", rx_tready, 4'b0000);
    chk("reset_tx_tvalid", tx_tvalid, 1'b0);
    chk("reset_tx_tlast", tx_tlast, 1'b0);
    chk("reset_tx_fields", {tx_tdata, tx_tstrb, tx_tkeep, tx_tdest, tx_tuser, tx_tid}, '0);
    chk("reset_grant", grant, 2'd0);
    chk("reset_busy", busy, 1'b0);
    @(negedge aclk);
    rx_tvalid = '0;
    areset_n  = 1'b1;

    for (int r = 0; r < 14; r++) begin
      rx_tvalid = tbl[r].v;
      tx_tready = tbl[r].rdy;
      #1;
      chk($sformatf("tbl%0d_rx_tready", r), rx_tready, tbl[r].e_rdy);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_grant);
      chk($sformatf("tbl%0d_tx_tvalid", r), tx_tvalid, tbl[r].e_txv);
      if (tbl[r].e_txv) begin
        chk($sformatf("tbl%0d_tx_tdata", r), tx_tdata, tbl[r].e_data);
        chk($sformatf("tbl%0d_tx_tlast", r), tx_tlast, 1'b1);
      end
      @(negedge aclk);
    end

    // Asynchronous reset in the middle of a packet, with an undrained output beat.
    do_reset();
    for (int n = 0; n < 4; n++) lq[2].push_back(mk(2, n, n == 3));
    en[2] = 1'b1; txr = 1'b1;
    step(); step();
    txr = 1'b0;
    step();
    areset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tx_tvalid", tx_tvalid, 1'b0);
    chk("async_rst_grant", grant, 2'd0);
    chk("async_rst_rx_tready", rx_tready, 4'b0000);
    @(negedge aclk);

    // Fairness: every lane continuously offers two 2-beat packets.
    do_reset();
    txr = 1'b1;
    for (int l = 0; l < NIN; l++)
      for (int n = 0; n < 4; n++) lq[l].push_back(mk(l, n, n % 2 == 1));
    en = '1;
    for (int c = 0; c < 100 && tx_log.size() < 16; c++) step();
    chk("fair_count", tx_log.size(), 16);
    for (int k = 0; k < tx_log.size(); k++)
      chk($sformatf("fair_order%0d", k), tx_log[k].data, exp_fair(k));

    // Backpressure: tx_tready low for five cycles mid-packet.
    do_reset();
    for (int n = 0; n < 3; n++) lq[1].push_back(mk(1, n, n == 2));
    en[1] = 1'b1;
    for (int c = 0; c < 40 && tx_log.size() < 3; c++) begin
      txr = !(c >= 3 && c < 8);
      step();
    end
    chk("bp_count", tx_log.size(), 3);
    for (int k = 0; k < tx_log.size(); k++)
      chk($sformatf("bp_order%0d", k), tx_log[k].data, {4'd1, 4'h0, 8'(k)});

    // Stall: granted lane 0 drops tvalid for four cycles while lane 1 waits.
    do_reset();
    txr = 1'b1;
    for (int n = 0; n < 3; n++) lq[0].push_back(mk(0, n, n == 2));
    lq[1].push_back(mk(1, 0, 1'b1));
    en = 4'b0011;
    step(); step();
    en[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN
      chk("stall_grant", grant, 2'd0);
      chk("stall_busy", busy, 1'b1);
`endif
    end
    en[0] = 1'b1;
    for (int c = 0; c < 50 && tx_log.size() < 4; c++) step();
`ifdef LOGIC_AXI4_STREAM_PACKET_ARBITER_LOCK_EN
    e_lane_data[0] = 16'h0000; e_lane_data[1] = 16'h0001; e_lane_data[2] = 16'h0002; e_lane_data[3] = 16'h1000;
`else
    e_lane_data[0] = 16'h0000; e_lane_data[1] = 16'h1000; e_lane_data[2] = 16'h0001; e_lane_data[3] = 16'h0002;
`endif
    chk("stall_count", tx_log.size(), 4);
    for (int k = 0; k < tx_log.size() && k < 4; k++)
      chk($sformatf("stall_order%0d", k), tx_log[k].data, e_lane_data[k]);

    // Randomized traffic against the model, then drain.
    do_reset();
    n_pushed = 0; n_tx = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < NIN; l++) begin
        if (lq[l].size() < 2 && $urandom_range(99) < 20) begin
          int unsigned len;
          len = $urandom_range(4, 1);
          for (int unsigned n = 0; n < len; n++) begin
            beat_t b;
            b.data = {4'(l), 12'($urandom)};
            b.strb = 2'($urandom); b.keep = 2'($urandom);
            b.dest = 4'($urandom); b.user = 4'($urandom); b.tid = 4'($urandom);
            b.last = (n == len - 1);
            lq[l].push_back(b);
          end
          n_pushed += len;
        end
        if (!held[l]) en[l] = ($urandom_range(99) < 65);
      end
      txr = ($urandom_range(99) < 70);
      step();
    end
    en = '1; txr = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (lq[0].size() == 0 && lq[1].size() == 0 && lq[2].size() == 0 && lq[3].size() == 0 && !m_txv) break;
      step();
    end
    chk("drain_done", (lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()) + 32'(m_txv), 0);
    chk("beat_count", n_tx, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
